// File: rtl/bcast_sched_pkg.sv
// bcast_sched_pkg: shared FSM state type, gap counter width and one-hot helper for the broadcast fanout scheduler
package bcast_sched_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SPREAD, S_GAP, S_DONE} state_t;
  localparam int GAP_W = 4;
  function automatic logic [31:0] onehot(input logic [4:0] idx);
    return 32'd1 << idx;
  endfunction
endpackage

// File: rtl/bcast_rr_arb.sv
// bcast_rr_arb: combinational round-robin pick from rr_ptr upward with wrap, plus the rr_ptr register
module bcast_rr_arb #(
  parameter int NREQ = 4,
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk1,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  output logic [PW-1:0]   gnt_idx
);
  logic [PW-1:0] rr_ptr;
  logic          found;
  function automatic logic [PW-1:0] wrap(input int a);
    return PW'((a >= NREQ) ? a - NREQ : a);
  endfunction
  // first valid requester at or after rr_ptr, wrapping explicitly past NREQ-1
  always_comb begin
    found = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && en && req_valid[wrap(int'(rr_ptr) + k)]) begin
        found = 1'b1;
        gnt_idx = wrap(int'(rr_ptr) + k);
      end
    end
    req_ready = found ? (NREQ'(1) << gnt_idx) : '0;
  end
  // move the pointer just past the winner on every accepted grant
  always_ff @(posedge clk1 or posedge rst)
    if (rst) rr_ptr <= '0;
    else if (found) rr_ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
endmodule

// File: rtl/bcast_fanout_sched.sv
// bcast_fanout_sched: arbitrate requesters onto one broadcast register, then stagger per-group capture enables (optional BCAST_PARITY_EN adds parity out and sticky group parity error)
module bcast_fanout_sched
  import bcast_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 1,
  parameter int NGRP = 2,
  parameter int GAP  = 0
) (
  input  logic               clk1,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [DW-1:0]      bcast_q,
  output logic [NGRP-1:0]    grp_cap_en,
  output logic               busy,
  output logic               done
`ifdef BCAST_PARITY_EN
  ,
  output logic               bcast_par,
  input  logic [NGRP-1:0]    grp_par_err,
  output logic               par_err
`endif
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW = (NGRP > 1) ? $clog2(NGRP) : 1;
  state_t           state;
  logic [GW-1:0]    grp_idx;
  logic [GAP_W-1:0] gap_cnt;
  logic [PW-1:0]    gnt_idx;
  logic [DW-1:0]    win_data;
  bcast_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk1     (clk1),
    .rst      (rst),
    .en       (state == S_IDLE && !rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .gnt_idx  (gnt_idx)
  );
  assign win_data   = req_data[gnt_idx*DW +: DW];
  assign grp_cap_en = (state == S_SPREAD) ? NGRP'(onehot(5'(grp_idx))) : '0;
  assign busy       = state != S_IDLE;
  assign done       = state == S_DONE;
  // sequencer: latch winner, one SPREAD cycle per group with optional gaps, then a single DONE cycle
  always_ff @(posedge clk1 or posedge rst)
    if (rst) begin
      state   <= S_IDLE;
      bcast_q <= '0;
      grp_idx <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (|req_ready) begin
            bcast_q <= win_data;
            grp_idx <= '0;
            state   <= S_SPREAD;
          end
        S_SPREAD:
          if (grp_idx == GW'(NGRP - 1)) state <= S_DONE;
          else if (GAP > 0) begin
            gap_cnt <= GAP_W'(GAP - 1);
            state   <= S_GAP;
          end else grp_idx <= grp_idx + 1'b1;
        S_GAP:
          if (gap_cnt == '0) begin
            grp_idx <= grp_idx + 1'b1;
            state   <= S_SPREAD;
          end else gap_cnt <= gap_cnt - 1'b1;
        default: state <= S_IDLE;
      endcase
    end
`ifdef BCAST_PARITY_EN
  // parity tracks bcast_q on the same grant edge; a group error during its enable cycle is sticky until reset
  always_ff @(posedge clk1 or posedge rst)
    if (rst) begin
      bcast_par <= 1'b0;
      par_err   <= 1'b0;
    end else begin
      if (|req_ready) bcast_par <= ^win_data;
      if (|(grp_par_err & grp_cap_en)) par_err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_bcast_fanout_sched.sv
// tb_bcast_fanout_sched: vector table, directed corner sequences and randomized model comparison for bcast_fanout_sched
module tb_bcast_fanout_sched;
  logic clk1 = 1'b0;
  logic rst = 1'b1;
  always #5 clk1 = ~clk1;

  logic [3:0] rv_a = '0, rd_a = '0, rr_a;
  logic       bq_a, busy_a, done_a;
  logic [1:0] ce_a;
  logic [2:0] rv_b = '0, rr_b, bq_b;
  logic [8:0] rd_b = '0;
  logic [1:0] ce_b;
  logic       busy_b, done_b;
`ifdef BCAST_PARITY_EN
  logic       par_a, perr_a, par_b, perr_b;
  logic [1:0] pe_a = '0, pe_b = '0;
`endif

  bcast_fanout_sched #(.NREQ(4), .DW(1), .NGRP(2), .GAP(0)) dut_a (
    .clk1(clk1), .rst(rst), .req_valid(rv_a), .req_data(rd_a), .req_ready(rr_a),
    .bcast_q(bq_a), .grp_cap_en(ce_a), .busy(busy_a), .done(done_a)
`ifdef BCAST_PARITY_EN
    , .bcast_par(par_a), .grp_par_err(pe_a), .par_err(perr_a)
`endif
  );

  bcast_fanout_sched #(.NREQ(3), .DW(3), .NGRP(2), .GAP(2)) dut_b (
    .clk1(clk1), .rst(rst), .req_valid(rv_b), .req_data(rd_b), .req_ready(rr_b),
    .bcast_q(bq_b), .grp_cap_en(ce_b), .busy(busy_b), .done(done_b)
`ifdef BCAST_PARITY_EN
    , .bcast_par(par_b), .grp_par_err(pe_b), .par_err(perr_b)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  typedef struct {
    logic [3:0] rv;
    logic [3:0] rd;
    logic [3:0] ready;
    logic [1:0] cap;
    logic       busy;
    logic       done;
    logic       bq;
  } vec_t;
  vec_t tv[13];

  // reference: grant = first pending requester from a rotating pointer; after a grant at T,
  // cycle T+p (p=1..len) enables group (p-1)/(gap+1) when (p-1) is a multiple of gap+1, done at p==len
  task automatic rand_run(input int which, input int nreq, input int dw, input int ngrp,
                          input int gap, input int cycles);
    int rr, pos, len, g, m;
    logic [31:0] pend, exp_bq, rvv, rdv, exp_cap, a_ready, a_cap, a_busy, a_done, a_bq;
    logic [31:0] pdata[4];
    rst = 1'b1;
    rv_a = '0;
    rv_b = '0;
    step();
    rst = 1'b0;
    rr = 0;
    pos = 0;
    pend = '0;
    exp_bq = '0;
    len = ngrp + (ngrp - 1) * gap + 1;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < nreq; i++)
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1'b1;
          pdata[i] = $urandom & ((32'd1 << dw) - 1);
        end
      rvv = pend;
      rdv = '0;
      for (int i = 0; i < nreq; i++) if (pend[i]) rdv |= pdata[i] << (i * dw);
      if (which == 0) begin
        rv_a = rvv[3:0];
        rd_a = rdv[3:0];
      end else begin
        rv_b = rvv[2:0];
        rd_b = rdv[8:0];
      end
      @(negedge clk1);
      a_ready = which ? 32'(rr_b) : 32'(rr_a);
      a_cap   = which ? 32'(ce_b) : 32'(ce_a);
      a_busy  = which ? 32'(busy_b) : 32'(busy_a);
      a_done  = which ? 32'(done_b) : 32'(done_a);
      a_bq    = which ? 32'(bq_b) : 32'(bq_a);
      g = -1;
      if (pos == 0) begin
        for (int k = 0; k < nreq; k++) if (g < 0 && pend[(rr + k) % nreq]) g = (rr + k) % nreq;
        chk("rnd_ready", a_ready, (g < 0) ? 32'd0 : 32'd1 << g);
        chk("rnd_busy_idle", a_busy, 0);
        chk("rnd_done_idle", a_done, 0);
        chk("rnd_cap_idle", a_cap, 0);
      end else begin
        m = pos - 1;
        exp_cap = (m % (gap + 1) == 0 && m / (gap + 1) < ngrp) ? 32'd1 << (m / (gap + 1)) : 32'd0;
        chk("rnd_ready_busy", a_ready, 0);
        chk("rnd_cap", a_cap, exp_cap);
        chk("rnd_busy", a_busy, 1);
        chk("rnd_done", a_done, (pos == len) ? 32'd1 : 32'd0);
      end
      chk("rnd_bq", a_bq, exp_bq);
      if (pos == 0 && g >= 0) begin
        exp_bq = pdata[g];
        pend[g] = 1'b0;
        rr = (g + 1) % nreq;
        pos = 1;
      end else if (pos > 0) pos = (pos == len) ? 0 : pos + 1;
      step();
    end
    rv_a = '0;
    rv_b = '0;
  endtask

  initial begin
    int k;
    int cap_e[7]   = '{0, 1, 0, 0, 2, 0, 0};
    int done_e[7]  = '{0, 0, 0, 0, 0, 1, 0};
    int busy_e[7]  = '{0, 1, 1, 1, 1, 1, 0};
    int ready_e[7] = '{1, 0, 0, 0, 0, 0, 0};
    //           rv       rd       ready    cap    busy  done  bq
    tv[0]  = '{4'b0001, 4'b0001, 4'b0001, 2'b00, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{4'b0000, 4'b0000, 4'b0000, 2'b01, 1'b1, 1'b0, 1'b1};
    tv[2]  = '{4'b0000, 4'b0000, 4'b0000, 2'b10, 1'b1, 1'b0, 1'b1};
    tv[3]  = '{4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1};
    tv[4]  = '{4'b0001, 4'b0000, 4'b0001, 2'b00, 1'b0, 1'b0, 1'b1};
    tv[5]  = '{4'b0101, 4'b0100, 4'b0000, 2'b01, 1'b1, 1'b0, 1'b0};
    tv[6]  = '{4'b0100, 4'b0100, 4'b0000, 2'b10, 1'b1, 1'b0, 1'b0};
    tv[7]  = '{4'b0100, 4'b0100, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b0};
    tv[8]  = '{4'b0100, 4'b0100, 4'b0100, 2'b00, 1'b0, 1'b0, 1'b0};
    tv[9]  = '{4'b0000, 4'b0000, 4'b0000, 2'b01, 1'b1, 1'b0, 1'b1};
    tv[10] = '{4'b0000, 4'b0000, 4'b0000, 2'b10, 1'b1, 1'b0, 1'b1};
    tv[11] = '{4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1};
    tv[12] = '{4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1};

    repeat (2) @(posedge clk1);
    #1;
    rst = 1'b0;
    @(negedge clk1);
    chk("rst_bq", bq_a, 0);
    chk("rst_cap", ce_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_bq_b", bq_b, 0);
    step();

    for (int i = 0; i < 13; i++) begin
      rv_a = tv[i].rv;
      rd_a = tv[i].rd;
      @(negedge clk1);
      chk($sformatf("tv%0d_ready", i), rr_a, tv[i].ready);
      chk($sformatf("tv%0d_cap", i), ce_a, tv[i].cap);
      chk($sformatf("tv%0d_busy", i), busy_a, tv[i].busy);
      chk($sformatf("tv%0d_done", i), done_a, tv[i].done);
      chk($sformatf("tv%0d_bq", i), bq_a, tv[i].bq);
      step();
    end

    rv_a = 4'b1000;
    rd_a = 4'b1000;
    @(negedge clk1);
    chk("rm_grant", rr_a, 4'b1000);
    step();
    rv_a = '0;
    @(negedge clk1);
    chk("rm_cap0", ce_a, 2'b01);
    step();
    #2;
    chk("rm_cap1", ce_a, 2'b10);
    rst = 1'b1;
    #1;
    chk("rm_cap_rst", ce_a, 0);
    chk("rm_busy_rst", busy_a, 0);
    chk("rm_done_rst", done_a, 0);
    chk("rm_bq_rst", bq_a, 0);
    step();
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk1);
      chk("rm_no_done", done_a, 0);
      chk("rm_idle", busy_a, 0);
      step();
    end
    rv_a = 4'b1010;
    @(negedge clk1);
    chk("rm_lowest", rr_a, 4'b0010);
    step();
    rv_a = '0;
    repeat (4) step();

    rst = 1'b1;
    step();
    rst = 1'b0;
    rv_a = 4'b1111;
    rd_a = 4'b0101;
    k = 0;
    for (int c = 0; c < 200 && k < 8; c++) begin
      @(negedge clk1);
      if (rr_a != 0) begin
        chk($sformatf("fair%0d", k), rr_a, 32'd1 << (k % 4));
        k++;
      end
      step();
    end
    if (k < 8) chk("fair_timeout", k, 8);
    rv_a = '0;
    repeat (4) step();

    rv_b = 3'b001;
    rd_b = 9'b000000101;
    for (int t = 0; t < 7; t++) begin
      if (t == 1) rv_b = '0;
`ifdef BCAST_PARITY_EN
      pe_b = (t == 4) ? 2'b10 : 2'b00;
`endif
      @(negedge clk1);
      chk($sformatf("gap%0d_cap", t), ce_b, cap_e[t]);
      chk($sformatf("gap%0d_done", t), done_b, done_e[t]);
      chk($sformatf("gap%0d_busy", t), busy_b, busy_e[t]);
      chk($sformatf("gap%0d_ready", t), rr_b, ready_e[t]);
      if (t >= 1) chk($sformatf("gap%0d_bq", t), bq_b, 3'b101);
`ifdef BCAST_PARITY_EN
      chk($sformatf("gap%0d_par", t), par_b, 0);
      chk($sformatf("gap%0d_perr", t), perr_b, (t >= 5) ? 32'd1 : 32'd0);
`endif
      step();
    end
`ifdef BCAST_PARITY_EN
    pe_b = '0;
    repeat (3) step();
    chk("perr_sticky", perr_b, 1);
    rst = 1'b1;
    #1;
    chk("perr_clr", perr_b, 0);
    step();
    rst = 1'b0;
`endif

    rand_run(0, 4, 1, 2, 0, 400);
    rand_run(1, 3, 3, 2, 2, 400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
